// File: rtl/e203_ifu_bhtbpu_if.sv
// Decode-side branch prediction bus: decoded control-transfer fields in, prediction out.
// Purely combinational bundle; no storage or timing of its own.
// Backpressure is carried by bpu_wait, which holds the decoded instruction in place.
// Ports: master drives pc/dec_*/ir_*/rf2bpu_*/upd_*/bpu_flush; slave drives the prediction results.
interface e203_ifu_bhtbpu_if #(
  parameter int PC_SIZE     = 32,
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
);
  // decoded instruction
  logic [PC_SIZE-1:0]     pc;
  logic                   dec_i_valid;
  logic                   dec_jal;
  logic                   dec_jalr;
  logic                   dec_bxx;
  logic                   dec_rv32;
  logic [XLEN-1:0]        dec_bjp_imm;
  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx;
  logic [RFIDX_WIDTH-1:0] dec_rdidx;
  // instruction-register hazard view and register-file read data
  logic                   ir_empty;
  logic                   ir_rs1en;
  logic                   jalr_rs1idx_cam_irrdidx;
  logic                   ir_valid_clr;
  logic [XLEN-1:0]        rf2bpu_x1;
  logic [XLEN-1:0]        rf2bpu_rs1;
  // resolution feedback from the execution unit
  logic                   upd_valid;
  logic [PC_SIZE-1:0]     upd_pc;
  logic                   upd_taken;
  logic                   bpu_flush;
  // prediction results
  logic                   bpu_wait;
  logic                   prdt_taken;
  logic [PC_SIZE-1:0]     prdt_pc_add_op1;
  logic [PC_SIZE-1:0]     prdt_pc_add_op2;
  logic                   bpu2rf_rs1_ena;
  logic                   ras_used;

  modport master (
    output pc, dec_i_valid, dec_jal, dec_jalr, dec_bxx, dec_rv32, dec_bjp_imm,
           dec_jalr_rs1idx, dec_rdidx, ir_empty, ir_rs1en, jalr_rs1idx_cam_irrdidx,
           ir_valid_clr, rf2bpu_x1, rf2bpu_rs1, upd_valid, upd_pc, upd_taken, bpu_flush,
    input  bpu_wait, prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2, bpu2rf_rs1_ena, ras_used
  );

  modport slave (
    input  pc, dec_i_valid, dec_jal, dec_jalr, dec_bxx, dec_rv32, dec_bjp_imm,
           dec_jalr_rs1idx, dec_rdidx, ir_empty, ir_rs1en, jalr_rs1idx_cam_irrdidx,
           ir_valid_clr, rf2bpu_x1, rf2bpu_rs1, upd_valid, upd_pc, upd_taken, bpu_flush,
    output bpu_wait, prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2, bpu2rf_rs1_ena, ras_used
  );
endinterface

// File: rtl/e203_ifu_bhtbpu.sv
// IFU branch predictor: 2-bit BHT for conditional branches, return-address stack for calls/returns.
// Prediction is combinational (0 cycles); BHT/RAS updates land on the next rising edge.
// bpu_wait stalls decode while a jalr base register is hazarded or being read from the register file.
// Ports: clk/rst (sync active-high), bus = slave side of e203_ifu_bhtbpu_if.
module e203_ifu_bhtbpu #(
  parameter int PC_SIZE     = 32,
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int BHT_ENTRIES = 16,
  parameter int RAS_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  e203_ifu_bhtbpu_if.slave  bus
);

  localparam int IDXW = $clog2(BHT_ENTRIES);
  localparam int RPW  = $clog2(RAS_DEPTH);
  localparam int RCW  = RPW + 1;

  // x1 (ra) and x5 (t0) are the link registers for call/return detection
  function automatic logic is_link(input logic [RFIDX_WIDTH-1:0] r);
    return (r == RFIDX_WIDTH'(1)) || (r == RFIDX_WIDTH'(5));
  endfunction

  // ---------------------------------------------------------------- state
  logic [BHT_ENTRIES-1:0] bht_vld;
  logic [1:0]             bht_cnt [BHT_ENTRIES];
  logic [PC_SIZE-1:0]     ras_mem [RAS_DEPTH];
  logic [RPW-1:0]         ras_ptr;   // next free slot; top is ras_ptr-1
  logic [RCW-1:0]         ras_cnt;   // valid entries, 0..RAS_DEPTH
  logic                   rdrf_r;    // rs1 register-file read issued last cycle

  // ---------------------------------------------------------------- classification
  logic rd_link, rs1_link, is_call, is_ret, is_coret;
  logic ras_empty, ras_full, ras_used;
  logic [RPW-1:0]     top_ptr;
  logic [PC_SIZE-1:0] ras_top;
  logic [PC_SIZE-1:0] push_val;

  assign rd_link   = is_link(bus.dec_rdidx);
  assign rs1_link  = is_link(bus.dec_jalr_rs1idx);
  assign is_call   = (bus.dec_jal | bus.dec_jalr) & rd_link;
  assign is_ret    = bus.dec_jalr & rs1_link & ~rd_link;
  assign is_coret  = bus.dec_jalr & rs1_link & rd_link;

  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == RCW'(RAS_DEPTH));
  assign top_ptr   = ras_ptr - RPW'(1);
  assign ras_top   = ras_mem[top_ptr];
  assign push_val  = bus.pc + (bus.dec_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));

  assign ras_used  = bus.dec_jalr & rs1_link & ~bus.dec_jal & (is_ret | is_coret) & ~ras_empty;

  // ---------------------------------------------------------------- jalr base dependency
  logic rs1_x0, rs1_x1, jalr_x1, jalr_xn;
  logic x1_wait, xn_dep, xn_dep_clr, rdrf_set;
  logic bpu_wait, commit;

  assign rs1_x0  = (bus.dec_jalr_rs1idx == '0);
  assign rs1_x1  = (bus.dec_jalr_rs1idx == RFIDX_WIDTH'(1));
  // a RAS hit supplies the target, so the base register never stalls decode
  assign jalr_x1 = bus.dec_jalr & rs1_x1 & ~ras_used;
  assign jalr_xn = bus.dec_jalr & ~rs1_x0 & ~rs1_x1 & ~ras_used;

  assign x1_wait    = bus.dec_i_valid & jalr_x1 & bus.jalr_rs1idx_cam_irrdidx;
  assign xn_dep     = bus.dec_i_valid & jalr_xn & ~bus.ir_empty;
  // the hazard is about to resolve: older instruction leaving IR or not reading rs1
  assign xn_dep_clr = xn_dep & (bus.ir_valid_clr | ~bus.ir_rs1en);
  // issue the register-file read once; data is usable the cycle after
  assign rdrf_set   = ~rdrf_r & bus.dec_i_valid & jalr_xn & (~xn_dep | xn_dep_clr);

  assign bpu_wait = x1_wait | xn_dep | rdrf_set;
  assign commit   = bus.dec_i_valid & ~bpu_wait;

  // ---------------------------------------------------------------- prediction
  logic [IDXW-1:0] ridx, widx;
  logic            bxx_taken;
  logic [PC_SIZE-1:0] op1;

  assign ridx = bus.pc[IDXW:1];
  assign widx = bus.upd_pc[IDXW:1];

  // unseen branch: static backward-taken/forward-not-taken from the offset sign
  assign bxx_taken = bht_vld[ridx] ? bht_cnt[ridx][1] : bus.dec_bjp_imm[XLEN-1];

  always_comb begin
    op1 = bus.pc;
    if (bus.dec_bxx | bus.dec_jal) begin
      op1 = bus.pc;
    end else if (bus.dec_jalr) begin
      if (rs1_x0)       op1 = '0;
      else if (ras_used) op1 = ras_top;
      else if (rs1_x1)  op1 = PC_SIZE'(bus.rf2bpu_x1);
      else              op1 = PC_SIZE'(bus.rf2bpu_rs1);
    end
  end

  assign bus.prdt_taken      = bus.dec_jal | bus.dec_jalr | (bus.dec_bxx & bxx_taken);
  assign bus.prdt_pc_add_op1 = op1;
  assign bus.prdt_pc_add_op2 = bus.dec_bjp_imm[PC_SIZE-1:0];
  assign bus.bpu_wait        = bpu_wait;
  assign bus.bpu2rf_rs1_ena  = rdrf_set;
  assign bus.ras_used        = ras_used;

  // ---------------------------------------------------------------- BHT update
  always_ff @(posedge clk) begin
    if (rst) begin
      bht_vld <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_cnt[i] <= 2'b01;
    end else if (bus.upd_valid) begin
      if (!bht_vld[widx]) begin
        bht_vld[widx] <= 1'b1;
        bht_cnt[widx] <= bus.upd_taken ? 2'b10 : 2'b01;
      end else if (bus.upd_taken) begin
        if (bht_cnt[widx] != 2'b11) bht_cnt[widx] <= bht_cnt[widx] + 2'b01;
      end else begin
        if (bht_cnt[widx] != 2'b00) bht_cnt[widx] <= bht_cnt[widx] - 2'b01;
      end
    end
  end

  // ---------------------------------------------------------------- RAS update
  logic ras_push, ras_pop, ras_repl;

  // coret on an empty stack degrades to a plain push
  assign ras_push = commit & ((is_call & ~is_ret & ~is_coret) | (is_coret & ras_empty));
  assign ras_pop  = commit & is_ret & ~ras_empty;
  assign ras_repl = commit & is_coret & ~ras_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (bus.bpu_flush) begin
      ras_cnt <= '0;
    end else if (ras_push) begin
      // circular write: when full this overwrites the oldest entry
      ras_mem[ras_ptr] <= push_val;
      ras_ptr          <= ras_ptr + RPW'(1);
      if (!ras_full) ras_cnt <= ras_cnt + RCW'(1);
    end else if (ras_pop) begin
      ras_ptr <= top_ptr;
      ras_cnt <= ras_cnt - RCW'(1);
    end else if (ras_repl) begin
      ras_mem[top_ptr] <= push_val;
    end
  end

  // ---------------------------------------------------------------- rs1 read tracker
  always_ff @(posedge clk) begin
    if (rst) rdrf_r <= 1'b0;
    else     rdrf_r <= rdrf_set;
  end

  logic unused_bits;
  assign unused_bits = ^{bus.upd_pc, bus.dec_bjp_imm, bus.rf2bpu_x1, bus.rf2bpu_rs1};

endmodule

// File: tb/tb_e203_ifu_bhtbpu.sv
// Self-checking bench for e203_ifu_bhtbpu: directed scenarios plus randomized traffic vs a reference model.
// Inputs change 1 ns after the rising edge; outputs are sampled before the next edge.
// Model: BHT as integer counters, RAS as a bounded queue, read tracker as a single flag.
module tb_e203_ifu_bhtbpu;
  localparam int PC_SIZE = 32;
  localparam int XLEN    = 32;
  localparam int RFW     = 5;
  localparam int N       = 16;
  localparam int D       = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  e203_ifu_bhtbpu_if #(.PC_SIZE(PC_SIZE), .XLEN(XLEN), .RFIDX_WIDTH(RFW)) bif ();

  e203_ifu_bhtbpu #(
    .PC_SIZE(PC_SIZE), .XLEN(XLEN), .RFIDX_WIDTH(RFW), .BHT_ENTRIES(N), .RAS_DEPTH(D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // ------------------------------------------------------------ reference model
  bit          m_vld [N];
  int          m_cnt [N];
  logic [31:0] m_ras [$];
  bit          m_rd_issued;

  bit          e_taken, e_wait, e_ena, e_used;
  logic [31:0] e_op1, e_op2;

  function automatic bit lnk(input int r);
    return (r == 1) || (r == 5);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 1'b0;
      m_cnt[i] = 1;
    end
    m_ras.delete();
    m_rd_issued = 1'b0;
  endtask

  task automatic model_eval();
    int idx;
    int rs1;
    bit can_read;
    idx     = int'((bif.pc >> 1) & (N - 1));
    rs1     = int'(bif.dec_jalr_rs1idx);
    e_used  = bif.dec_jalr && !bif.dec_jal && lnk(rs1) && (m_ras.size() > 0);
    e_taken = bif.dec_jal || bif.dec_jalr ||
              (bif.dec_bxx && (m_vld[idx] ? (m_cnt[idx] >= 2) : bif.dec_bjp_imm[31]));
    e_wait  = 1'b0;
    e_ena   = 1'b0;
    e_op2   = bif.dec_bjp_imm;
    e_op1   = bif.pc;
    if (!(bif.dec_bxx || bif.dec_jal) && bif.dec_jalr) begin
      if (rs1 == 0) e_op1 = 32'h0;
      else if (e_used) e_op1 = m_ras[$];
      else if (rs1 == 1) begin
        e_op1  = bif.rf2bpu_x1;
        e_wait = bif.dec_i_valid && bif.jalr_rs1idx_cam_irrdidx;
      end else begin
        e_op1 = bif.rf2bpu_rs1;
        if (bif.dec_i_valid) begin
          can_read = bif.ir_empty || bif.ir_valid_clr || !bif.ir_rs1en;
          e_ena    = !m_rd_issued && can_read;
          e_wait   = !bif.ir_empty || e_ena;
        end
      end
    end
  endtask

  task automatic ras_push(input logic [31:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > D) void'(m_ras.pop_front());
  endtask

  task automatic model_update();
    int          w;
    int          rs1;
    int          rd;
    logic [31:0] pv;
    if (rst) begin
      model_reset();
      return;
    end
    if (bif.upd_valid) begin
      w = int'((bif.upd_pc >> 1) & (N - 1));
      if (!m_vld[w]) begin
        m_vld[w] = 1'b1;
        m_cnt[w] = bif.upd_taken ? 2 : 1;
      end else if (bif.upd_taken) m_cnt[w] = (m_cnt[w] < 3) ? m_cnt[w] + 1 : 3;
      else                         m_cnt[w] = (m_cnt[w] > 0) ? m_cnt[w] - 1 : 0;
    end
    rs1 = int'(bif.dec_jalr_rs1idx);
    rd  = int'(bif.dec_rdidx);
    pv  = bif.pc + (bif.dec_rv32 ? 32'd4 : 32'd2);
    if (bif.bpu_flush) m_ras.delete();
    else if (bif.dec_i_valid && !e_wait) begin
      if (bif.dec_jalr && lnk(rs1)) begin
        if (lnk(rd)) begin
          if (m_ras.size() > 0) m_ras[m_ras.size() - 1] = pv;
          else ras_push(pv);
        end else if (m_ras.size() > 0) void'(m_ras.pop_back());
      end else if ((bif.dec_jal || bif.dec_jalr) && lnk(rd)) ras_push(pv);
    end
    m_rd_issued = e_ena;
  endtask

  // one clock: model comparison before the edge, then advance model and DUT together
  task automatic cycle();
    @(negedge clk);
    model_eval();
    chk("taken", 32'(bif.prdt_taken), 32'(e_taken));
    chk("wait", 32'(bif.bpu_wait), 32'(e_wait));
    chk("rs1_ena", 32'(bif.bpu2rf_rs1_ena), 32'(e_ena));
    chk("ras_used", 32'(bif.ras_used), 32'(e_used));
    chk("op1", bif.prdt_pc_add_op1, e_op1);
    chk("op2", bif.prdt_pc_add_op2, e_op2);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.pc = '0; bif.dec_i_valid = 0; bif.dec_jal = 0; bif.dec_jalr = 0; bif.dec_bxx = 0;
    bif.dec_rv32 = 1; bif.dec_bjp_imm = '0; bif.dec_jalr_rs1idx = '0; bif.dec_rdidx = '0;
    bif.ir_empty = 1; bif.ir_rs1en = 0; bif.jalr_rs1idx_cam_irrdidx = 0; bif.ir_valid_clr = 0;
    bif.rf2bpu_x1 = 32'hDEAD0000; bif.rf2bpu_rs1 = 32'h12345678;
    bif.upd_valid = 0; bif.upd_pc = '0; bif.upd_taken = 0; bif.bpu_flush = 0;
  endtask

  task automatic bxx(input logic [31:0] pc, input logic [31:0] imm);
    idle();
    bif.dec_i_valid = 1; bif.dec_bxx = 1; bif.pc = pc; bif.dec_bjp_imm = imm;
  endtask

  task automatic upd(input logic [31:0] pc, input bit taken);
    idle();
    bif.upd_valid = 1; bif.upd_pc = pc; bif.upd_taken = taken;
  endtask

  task automatic jal_call(input logic [31:0] pc);
    idle();
    bif.dec_i_valid = 1; bif.dec_jal = 1; bif.pc = pc; bif.dec_rdidx = 5'd1;
  endtask

  task automatic jalr_ret(input bit cam);
    idle();
    bif.dec_i_valid = 1; bif.dec_jalr = 1; bif.dec_jalr_rs1idx = 5'd1; bif.dec_rdidx = 5'd0;
    bif.pc = 32'h300; bif.jalr_rs1idx_cam_irrdidx = cam;
  endtask

  int regs [5] = '{0, 1, 5, 7, 3};

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // reset state
    #2; chk("rst_wait", 32'(bif.bpu_wait), 32'h0);
    chk("rst_ras_used", 32'(bif.ras_used), 32'h0);
    cycle();

    // static prediction on unseen branches
    bxx(32'h100, 32'hFFFF_FFF0); #2;
    chk("static_back", 32'(bif.prdt_taken), 32'h1);
    chk("bxx_op1", bif.prdt_pc_add_op1, 32'h100);
    cycle();
    bxx(32'h100, 32'h10); #2;
    chk("static_fwd", 32'(bif.prdt_taken), 32'h0);
    cycle();

    // training and saturation
    upd(32'h100, 0); cycle();
    upd(32'h100, 0); cycle();
    bxx(32'h100, 32'hFFFF_FFF0); #2;
    chk("trained_nt", 32'(bif.prdt_taken), 32'h0);
    cycle();
    repeat (3) begin upd(32'h100, 1); cycle(); end
    bxx(32'h100, 32'hFFFF_FFF0); #2;
    chk("trained_t", 32'(bif.prdt_taken), 32'h1);
    cycle();
    upd(32'h100, 1); cycle();
    upd(32'h100, 0); cycle();
    bxx(32'h100, 32'h10); #2;
    chk("sat_hold", 32'(bif.prdt_taken), 32'h1);
    cycle();
    upd(32'h100, 0); cycle();
    bxx(32'h100, 32'h10); #2;
    chk("sat_drop", 32'(bif.prdt_taken), 32'h0);
    cycle();

    // call then return through the RAS
    jal_call(32'h200); #2;
    chk("call_wait", 32'(bif.bpu_wait), 32'h0);
    cycle();
    jalr_ret(1); #2;
    chk("ret1_wait", 32'(bif.bpu_wait), 32'h0);
    chk("ret1_used", 32'(bif.ras_used), 32'h1);
    chk("ret1_op1", bif.prdt_pc_add_op1, 32'h204);
    cycle();
    jalr_ret(1); #2;
    chk("ret2_used", 32'(bif.ras_used), 32'h0);
    chk("ret2_wait", 32'(bif.bpu_wait), 32'h1);
    cycle();

    // overflow: oldest overwritten, LIFO order, then x1 fallback
    for (int i = 0; i <= D; i++) begin jal_call(32'(i * 16)); cycle(); end
    for (int i = D; i >= 0; i--) begin
      jalr_ret(0); #2;
      chk("lifo_used", 32'(bif.ras_used), (i > 0) ? 32'h1 : 32'h0);
      chk("lifo_op1", bif.prdt_pc_add_op1, (i > 0) ? 32'(i * 16 + 4) : 32'hDEAD0000);
      cycle();
    end
    jal_call(32'h40); cycle();
    jal_call(32'h80); bif.bpu_flush = 1; cycle();
    jalr_ret(0); #2;
    chk("flush_used", 32'(bif.ras_used), 32'h0);
    cycle();

    // jalr through a general register with a pending IR hazard
    idle();
    bif.dec_i_valid = 1; bif.dec_jalr = 1; bif.dec_jalr_rs1idx = 5'd7;
    bif.ir_empty = 0; bif.ir_rs1en = 1; #2;
    chk("xn_dep_wait", 32'(bif.bpu_wait), 32'h1);
    chk("xn_dep_ena", 32'(bif.bpu2rf_rs1_ena), 32'h0);
    cycle();
    bif.ir_empty = 1; #2;
    chk("xn_rd_ena", 32'(bif.bpu2rf_rs1_ena), 32'h1);
    chk("xn_rd_wait", 32'(bif.bpu_wait), 32'h1);
    cycle();
    #2;
    chk("xn_go_wait", 32'(bif.bpu_wait), 32'h0);
    chk("xn_go_op1", bif.prdt_pc_add_op1, 32'h12345678);
    cycle();
    idle(); cycle();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int kind;
      idle();
      kind = $urandom_range(0, 3);
      bif.dec_i_valid = ($urandom_range(0, 3) != 0);
      bif.dec_jal  = (kind == 1);
      bif.dec_jalr = (kind == 2);
      bif.dec_bxx  = (kind == 3);
      bif.dec_rv32 = $urandom_range(0, 1);
      bif.pc = 32'($urandom_range(0, 63) * 2);
      bif.dec_bjp_imm = $urandom;
      bif.dec_jalr_rs1idx = 5'(regs[$urandom_range(0, 4)]);
      bif.dec_rdidx = 5'(regs[$urandom_range(0, 4)]);
      bif.ir_empty = $urandom_range(0, 1);
      bif.ir_rs1en = $urandom_range(0, 1);
      bif.ir_valid_clr = ($urandom_range(0, 3) == 0);
      bif.jalr_rs1idx_cam_irrdidx = $urandom_range(0, 1);
      bif.rf2bpu_x1 = $urandom;
      bif.rf2bpu_rs1 = $urandom;
      bif.upd_valid = $urandom_range(0, 1);
      bif.upd_pc = 32'($urandom_range(0, 63) * 2);
      bif.upd_taken = $urandom_range(0, 1);
      bif.bpu_flush = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
